// File: rtl/bcd_adder_behav_if.sv
// Operand/result bundle for the single-digit BCD adder.
// Master drives operands and consumes the registered result.
interface bcd_adder_behav_if;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       c0;
  logic       sub;
  logic [3:0] s;
  logic       cout;
  logic       err;
  logic       out_valid;

  modport master (
    output in_valid, a, b, c0, sub,
    input  s, cout, err, out_valid
  );

  modport slave (
    input  in_valid, a, b, c0, sub,
    output s, cout, err, out_valid
  );
endinterface

// File: rtl/bcd_adder_behav.sv
// Registered single-digit BCD adder, one result per captured operand pair.
// Define BCD_SUB_EN to honour sub (nine's-complement subtract path).
module bcd_adder_behav (
  input  logic               clk,
  input  logic               rst,
  bcd_adder_behav_if.slave   bus
);

  logic [3:0] bo;
  logic [4:0] t;
  logic [4:0] t_adj;

  logic [3:0] s_d, s_q;
  logic       cout_d, cout_q;
  logic       err_d, err_q;
  logic       valid_d, valid_q;

`ifdef BCD_SUB_EN
  always_comb begin
    bo = bus.b;
    if (bus.sub) bo = 4'd9 - bus.b;
  end
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign bo = bus.b;
`endif

  // 5-bit sum keeps out-of-range operands from wrapping before correction
  assign t     = {1'b0, bus.a} + {1'b0, bo} + {4'd0, bus.c0};
  assign t_adj = t + 5'd6;

  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    err_d   = err_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      err_d = (bus.a > 4'd9) || (bus.b > 4'd9);
      if (t > 5'd9) begin
        s_d    = t_adj[3:0];
        cout_d = 1'b1;
      end else begin
        s_d    = t[3:0];
        cout_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= 4'd0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_bcd_adder_behav.sv
// Scoreboard bench for bcd_adder_behav: directed digits plus random traffic.
// A reference model predicts each result; a monitor checks it on out_valid.
module tb_bcd_adder_behav;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bcd_adder_behav_if bus ();

  bcd_adder_behav dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_q[$];
  logic       v_seen   = 1'b0;
  logic       rst_seen = 1'b1;
  logic [5:0] held     = 6'd0;
  logic       run_mon  = 1'b0;

  function automatic logic [5:0] model(int a, int b, int c0, int sub);
    int bo, t, sv;
    logic co, er;
    bo = b;
`ifdef BCD_SUB_EN
    if (sub != 0) bo = (9 - b + 16) % 16;
`endif
    t = a + bo + c0;
    if (t > 9) begin
      sv = (t + 6) % 16;
      co = 1'b1;
    end else begin
      sv = t;
      co = 1'b0;
    end
    er = (a > 9) || (b > 9);
    return {sv[3:0], co, er};
  endfunction

  task automatic drive(input logic v, input int a, input int b,
                       input int c0, input int sub, input logic r,
                       input logic use_exp, input logic [5:0] exp_v);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.a        = 4'(a);
    bus.b        = 4'(b);
    bus.c0       = 1'(c0);
    bus.sub      = 1'(sub);
    if (v && !r) begin
      if (use_exp) exp_q.push_back(exp_v);
      else         exp_q.push_back(model(a, b, c0, sub));
    end
  endtask

  always @(posedge clk) begin
    v_seen   <= bus.in_valid && !rst;
    rst_seen <= rst;
  end

  always @(negedge clk) begin
    if (run_mon) begin
      logic [5:0] got;
      got = {bus.s, bus.cout, bus.err};
      checks++;
      if (bus.out_valid !== v_seen) begin
        failures++;
        $display("FAIL out_valid got=%b exp=%b", bus.out_valid, v_seen);
      end
      if (rst_seen) begin
        held = 6'd0;
        checks++;
        if (got !== 6'd0) begin
          failures++;
          $display("FAIL reset_outs got=%h exp=00", got);
        end
      end else if (bus.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got=%h exp=none", got);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          held = e;
          if (got !== e) begin
            failures++;
            $display("FAIL result s/cout/err got=%h/%b/%b exp=%h/%b/%b",
                     got[5:2], got[1], got[0], e[5:2], e[1], e[0]);
          end
        end
      end else begin
        checks++;
        if (got !== held) begin
          failures++;
          $display("FAIL hold got=%h exp=%h", got, held);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.a = 4'd0;
    bus.b = 4'd0;
    bus.c0 = 1'b0;
    bus.sub = 1'b0;
    repeat (2) @(posedge clk);
    run_mon = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 6'd0);

    drive(1'b1, 0, 0, 0, 0, 1'b0, 1'b1, {4'd0, 1'b0, 1'b0});
    drive(1'b1, 2, 3, 0, 0, 1'b0, 1'b1, {4'd5, 1'b0, 1'b0});
    drive(1'b1, 4, 7, 0, 0, 1'b0, 1'b1, {4'd1, 1'b1, 1'b0});
    drive(1'b1, 8, 9, 1, 0, 1'b0, 1'b1, {4'd8, 1'b1, 1'b0});
    drive(1'b1, 4, 5, 1, 0, 1'b0, 1'b1, {4'd0, 1'b1, 1'b0});
    drive(1'b1, 8, 10, 1, 0, 1'b0, 1'b1, {4'd9, 1'b1, 1'b1});
    drive(1'b0, 1, 1, 0, 0, 1'b0, 1'b0, 6'd0);
    drive(1'b0, 3, 3, 1, 0, 1'b0, 1'b0, 6'd0);
    drive(1'b1, 9, 9, 1, 0, 1'b0, 1'b1, {4'd9, 1'b1, 1'b0});
    drive(1'b1, 15, 15, 1, 0, 1'b0, 1'b1, {4'd5, 1'b1, 1'b1});
`ifdef BCD_SUB_EN
    drive(1'b1, 7, 3, 1, 1, 1'b0, 1'b1, {4'd4, 1'b1, 1'b0});
    drive(1'b1, 3, 7, 1, 1, 1'b0, 1'b1, {4'd6, 1'b0, 1'b0});
`else
    drive(1'b1, 7, 3, 1, 1, 1'b0, 1'b1, {4'd1, 1'b1, 1'b0});
    drive(1'b1, 3, 7, 1, 1, 1'b0, 1'b1, {4'd1, 1'b1, 1'b0});
`endif
    drive(1'b1, 6, 6, 0, 0, 1'b1, 1'b0, 6'd0);
    drive(1'b0, 6, 6, 0, 0, 1'b0, 1'b0, 6'd0);
    drive(1'b1, 1, 2, 0, 0, 1'b0, 1'b1, {4'd3, 1'b0, 1'b0});

    for (int i = 0; i < 400; i++) begin
      int a, b;
      logic v, r;
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15)
                                      : $urandom_range(0, 9);
      b = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15)
                                      : $urandom_range(0, 9);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 39) == 0);
      drive(v, a, b, $urandom_range(0, 1), $urandom_range(0, 1),
            r, 1'b0, 6'd0);
    end

    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    run_mon = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_adder_behav.md
BCD_ADDER_BEHAV -- requirements
Module: bcd_adder_behav

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  qualifies a, b, c0 and sub for capture this cycle.
REQ-005 a  input  4  BCD digit operand A; legal range 0-9.
REQ-006 b  input  4  BCD digit operand B; legal range 0-9.
REQ-007 c0  input  1  decimal carry-in; acts as borrow-complement in subtract mode.
REQ-008 sub  input  1  mode: 0 = add, 1 = subtract; ignored when BCD_SUB_EN is undefined.
REQ-009 s  output  4  registered BCD sum/difference digit.
REQ-010 cout  output  1  registered decimal carry-out; in subtract mode 1 = no borrow (result non-negative).
REQ-011 err  output  1  registered flag; 1 when the captured a or b exceeded 9.
REQ-012 out_valid  output  1  registered; 1 for the cycle after a capture.

Function
REQ-013 Operand selection SHALL be bo = b in add mode; bo = (9 - b) mod 16 (nine's complement) in subtract mode.
REQ-014 The binary intermediate SHALL be t = a + bo + c0, computed 5 bits wide (range 0-31, no truncation).
REQ-015 If t > 9: s SHALL be (t + 6) mod 16 and cout SHALL be 1; otherwise s = t[3:0] and cout = 0.
REQ-016 Out-of-range operands SHALL be processed by the same arithmetic without saturation; only err flags them.
REQ-017 err SHALL be (a > 9) OR (b > 9) for the captured operands, independent of mode.
REQ-018 On a rising edge with rst=0 and in_valid=1, s, cout and err SHALL load the result of the current inputs (latency 1 cycle).
REQ-019 On a rising edge with rst=0 and in_valid=0, s, cout and err SHALL hold their values.
REQ-020 out_valid SHALL equal in_valid registered one cycle; back-to-back in_valid every cycle SHALL yield one result per cycle.
REQ-021 Subtract with c0=1 SHALL yield a - b when a >= b (cout=1), and the ten's complement 10 - (b - a) when a < b (cout=0).
REQ-022 Outputs SHALL be purely registered; no combinational path from inputs to outputs.

Reset
REQ-023 When rst=1 at a rising edge: s=0, cout=0, err=0, out_valid=0, regardless of in_valid.
REQ-024 Reset asserted mid-stream SHALL discard the operand presented that cycle; operation resumes on the first edge with rst=0.

Configuration
REQ-025 Macro BCD_SUB_EN defined: sub input honoured and the nine's-complement path of REQ-013 is built.
REQ-026 Macro BCD_SUB_EN undefined: sub port remains present but is ignored; the block SHALL behave as add-only (bo = b).

Verification
REQ-027 Add: a=0, b=0, c0=0 -> next cycle s=0, cout=0, err=0, out_valid=1.
REQ-028 Add: a=2, b=3, c0=0 -> s=5, cout=0; a=4, b=7, c0=0 -> s=1, cout=1.
REQ-029 Add with carry: a=8, b=9, c0=1 -> s=8, cout=1; a=4, b=5, c0=1 -> s=0, cout=1.
REQ-030 Invalid operand: a=8, b=10, c0=1 -> s=9, cout=1, err=1.
REQ-031 Subtract (BCD_SUB_EN): a=7, b=3, c0=1 -> s=4, cout=1; a=3, b=7, c0=1 -> s=6, cout=0.
REQ-032 Control: in_valid=0 holds the previous s/cout/err; rst=1 with in_valid=1 -> all outputs 0 on the next cycle.
